// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state/owner enums and the clear fill value for the RAM port arbiter
package ram_arb_pkg;
  typedef enum logic {CLEAR, RUN} arb_state_t;
  typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
  localparam logic CLEAR_DATA = 1'b0;
endpackage

// File: rtl/ram_clear_sweeper.sv
// ram_clear_sweeper: walks every RAM address once while en (clk/rst in; address, wren, last, done out)
module ram_clear_sweeper #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wren,
  output logic                  last,
  output logic                  done
);
  logic [ADDR_WIDTH:0] clr_cnt;
  assign address = clr_cnt[ADDR_WIDTH-1:0];
  assign done    = clr_cnt[ADDR_WIDTH];
  assign wren    = en && !done;
  assign last    = wren && (&clr_cnt[ADDR_WIDTH-1:0]);
  always_ff @(posedge clk or posedge rst)
    if (rst) clr_cnt <= '0;
    else if (wren) clr_cnt <= clr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears the RAM after reset, then shares port A between cpu_* and dbg_* requesters (ram_* to RAM, init_done when cleared)
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1,
  parameter int MAX_DBG_WAIT   = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);
  localparam int WW = $clog2(MAX_DBG_WAIT + 1);
  arb_state_t state, state_nxt;
  owner_t rd_owner, owner_nxt;
  logic [WW-1:0] dbg_wait;
  logic [ADDR_WIDTH-1:0] addr_q, clr_addr;
  logic [DATA_WIDTH-1:0] data_q;
  logic clr_wren, clr_last, clr_done, run, starve;
  ram_clear_sweeper #(.ADDR_WIDTH(ADDR_WIDTH)) u_sweep (
    .clk(Clk),
    .rst(Reset),
    .en(state == CLEAR),
    .address(clr_addr),
    .wren(clr_wren),
    .last(clr_last),
    .done(clr_done)
  );
  // Reset gates the combinational outputs so they drop the moment it asserts.
  always_comb begin
    run         = state == RUN && !Reset;
    starve      = dbg_wait >= WW'(MAX_DBG_WAIT);
    cpu_gnt     = run && cpu_req && !(dbg_req && starve);
    dbg_gnt     = run && dbg_req && !cpu_gnt;
    ram_wren    = Reset ? 1'b0 : state == CLEAR ? clr_wren : (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    ram_address = Reset ? '0 : state == CLEAR ? clr_addr : cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : addr_q;
    ram_data    = Reset ? '0 : state == CLEAR ? {DATA_WIDTH{CLEAR_DATA}} : cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : data_q;
    state_nxt   = state == CLEAR && clr_last ? RUN : state;
    owner_nxt   = cpu_gnt && !cpu_we ? CPU : dbg_gnt && !dbg_we ? DBG : NONE;
    cpu_rvalid  = rd_owner == CPU;
    dbg_rvalid  = rd_owner == DBG;
    cpu_rdata   = cpu_rvalid ? ram_q : '0;
    dbg_rdata   = dbg_rvalid ? ram_q : '0;
    init_done   = clr_done || CLEAR_ON_RESET == 0;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state    <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      rd_owner <= NONE;
      dbg_wait <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      rd_owner <= owner_nxt;
      dbg_wait <= !dbg_req || dbg_gnt ? '0 : starve ? dbg_wait : dbg_wait + WW'(1);
      addr_q   <= ram_address;
      data_q   <= ram_data;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single read/write port of the data RAM between the CPU data path and a debug/loader host port.
- Zero-fills the whole RAM after every reset before granting any access, so the CPU never needs the RAM's second port for clearing.
- Sits between the cpu_garage top, the cpu data interface (in_m/out_m/write_m/data_addr) and the ram port A.

Parameters:
- DATA_WIDTH, 16, RAM word width in bits.
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = sweep-zero RAM after reset; 0 = go straight to RUN.
- MAX_DBG_WAIT, 4, cycles a pending debug request may be denied before it gets forced priority.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request (read or write)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_WIDTH  debug word address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_WIDTH  debug read data
- ram_address  out  ADDR_WIDTH  to RAM port A address
- ram_data  out  DATA_WIDTH  to RAM port A write data
- ram_wren  out  1  to RAM port A write enable
- ram_q  in  DATA_WIDTH  RAM port A read data, 1-cycle synchronous latency
- init_done  out  1  high once the clear sweep is complete

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-high.
- While Reset is high:
  - state = CLEAR, or RUN if CLEAR_ON_RESET = 0.
  - clr_cnt = 0, dbg_wait = 0, rd_owner = NONE.
  - All outputs 0, except init_done = !CLEAR_ON_RESET.
- States: CLEAR and RUN.
- CLEAR:
  - Each cycle: ram_address = clr_cnt, ram_data = 0, ram_wren = 1; clr_cnt increments.
  - Grants are 0; requests are ignored (requesters hold and retry).
  - On the cycle clr_cnt = 2**ADDR_WIDTH-1 is written, next state = RUN and init_done = 1 (registered). The sweep takes exactly 2**ADDR_WIDTH cycles after Reset deasserts.
- RUN, grant decision (combinational, same cycle):
  - Only cpu_req: CPU granted.
  - Only dbg_req: debug granted.
  - Both: CPU granted unless dbg_wait >= MAX_DBG_WAIT, in which case debug is granted.
  - At most one grant per cycle.
- RUN, RAM drive from the granted requester:
  - ram_address = addr, ram_data = wdata, ram_wren = gnt & we.
  - No grant: ram_wren = 0; ram_address and ram_data hold their last values (registered hold).
- Starvation counter dbg_wait (width clog2(MAX_DBG_WAIT+1)):
  - Increments when dbg_req & !dbg_gnt; saturates at MAX_DBG_WAIT.
  - Clears on dbg_gnt or on !dbg_req.
- Read return:
  - A granted read (we = 0) registers rd_owner = CPU or DBG. Otherwise rd_owner = NONE.
  - Next cycle: the owner's rvalid = 1 and its rdata = ram_q. The other requester's rvalid = 0 and its rdata = 0.
  - Back-to-back reads from alternating requesters return in grant order, one per cycle.
- Write then read of the same address in consecutive cycles returns the new data (RAM old-data/new-data hazard does not arise because the read is issued in a later cycle).
- Reset mid-operation (CLEAR or RUN): asynchronous abort. Any in-flight rvalid is dropped, the sweep restarts from address 0, and init_done falls immediately.
- Address arithmetic: clr_cnt is ADDR_WIDTH+1 bits, and the terminal compare is on the low ADDR_WIDTH bits, so there is no wrap-around write.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum arb_state_t {CLEAR, RUN}.
  - typedef enum owner_t {NONE, CPU, DBG}.
  - Constant CLEAR_DATA = '0.
- One sub-module, ram_clear_sweeper: clr_cnt, terminal detect and done flag, outputs address/wren.
- Arbitration, starvation counter and read routing live in the top of the block.

Test Plan:
1. Reset high 3 cycles, then release, ADDR_WIDTH = 10 -> ram_wren = 1 with addresses 0..1023 over 1024 consecutive cycles, all data 0; init_done rises on cycle 1024; cpu_req held throughout sees cpu_gnt = 0 until RUN.
2. In RUN, CPU write 0x1234 to 0x05, then CPU read 0x05 -> cpu_gnt each cycle; cpu_rvalid = 1 one cycle after the read grant with cpu_rdata = 0x1234; dbg_rvalid stays 0.
3. cpu_req and dbg_req both held continuously, MAX_DBG_WAIT = 4 -> CPU granted 4 cycles, debug granted on the 5th; dbg_wait returns to 0 and the pattern repeats 4:1.
4. CPU read 0x10 (holding 0xAAAA), next cycle debug read 0x11 (holding 0x5555) -> cpu_rvalid/0xAAAA, then dbg_rvalid/0x5555 on the following cycle; never both rvalid high together.
5. Reset asserted when the sweep reaches address 300 -> outputs go to 0 asynchronously; after release the sweep restarts at 0, and init_done rises 1024 cycles later.
6. Debug read granted, Reset pulsed before the return cycle -> dbg_rvalid never asserts; with CLEAR_ON_RESET = 0, init_done = 1 during reset and the first grant occurs on the cycle after release.
